// File: rtl/shift_reg.sv
// Registered arithmetic right shifter: data_out <= floor(signed(data_in) / 2^shift_in).
// Optional build macro SHIFT_REG_ROUND_EN switches to round-half-up; ports are identical in both builds.
module shift_reg #(
    parameter int WIDTH = 8,
    parameter int SHW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shift_in,
    output logic [WIDTH-1:0] data_out
);

    // Clamped shift amounts never exceed WIDTH, so CW bits are enough to hold them.
    localparam int CW = $clog2(WIDTH + 1);

    logic [31:0]             amt_wide;
    logic                    amt_sat;
    logic [CW-1:0]           amt;
    logic signed [WIDTH:0]   ext;
    logic signed [WIDTH:0]   shifted;
    logic [WIDTH-1:0]        result;
`ifdef SHIFT_REG_ROUND_EN
    logic signed [WIDTH:0]   bias;
    logic signed [WIDTH:0]   biased;
`endif

    // Large shift amounts are clamped rather than wrapped; WIDTH already floods every bit.
    always_comb begin
        amt_wide = 32'(shift_in);
        amt_sat  = (amt_wide >= 32'(WIDTH));
        amt      = amt_sat ? CW'(WIDTH) : CW'(amt_wide);
        ext      = {data_in[WIDTH-1], data_in};
    end

`ifdef SHIFT_REG_ROUND_EN
    // Half an LSB of the result is added one bit wider than the operand so the sum cannot overflow.
    always_comb begin
        bias    = '0;
        biased  = ext;
        shifted = ext;
        result  = data_in;
        if (amt_sat) begin
            result = '0;
        end else if (amt != '0) begin
            bias    = {{WIDTH{1'b0}}, 1'b1} << (amt - CW'(1));
            biased  = ext + bias;
            shifted = biased >>> amt;
            result  = shifted[WIDTH-1:0];
        end
    end
`else
    always_comb begin
        shifted = ext >>> amt;
        result  = shifted[WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else begin
            data_out <= result;
        end
    end

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg: directed test-plan vectors, async reset checks,
// and randomized stimulus against a floor-division reference model.
module tb_shift_reg;

    localparam int WIDTH = 8;
    localparam int SHW   = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shift_in;
    logic [WIDTH-1:0] data_out;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    shift_reg #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .shift_in (shift_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: floor division of the signed value by 2^s, with optional half-LSB bias.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int unsigned s);
        int x;
        int p;
        int q;
        x = $signed(d);
`ifdef SHIFT_REG_ROUND_EN
        if (s == 0) return d;
        if (s >= WIDTH) return '0;
        x = x + (2 ** (s - 1));
`endif
        if (s >= 16) return (x < 0) ? '1 : '0;
        p = 2 ** s;
        q = x / p;
        if (x < 0 && q * p != x) q = q - 1;
        return q[WIDTH-1:0];
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] exp);
        checks++;
        assert (data_out === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, data_out, exp);
        end
    endtask

    // Drive on the falling edge, then check #1 after the capturing rising edge.
    task automatic step(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s, input string tag);
        @(negedge clk);
        data_in  = d;
        shift_in = s;
        exp_q.push_back(ref_shift(d, 32'(s)));
        @(posedge clk);
        #1;
        check(tag, exp_q.pop_front());
    endtask

    task automatic step_const(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s,
                              input logic [WIDTH-1:0] exp, input string tag);
        @(negedge clk);
        data_in  = d;
        shift_in = s;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   s;

        rst      = 1'b1;
        data_in  = 8'h55;
        shift_in = '0;
        #2;
        check("reset_async", 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", 8'h55);

        step_const(8'h55, 8'd0,   8'h55, "pass_through");
`ifdef SHIFT_REG_ROUND_EN
        step_const(8'h55, 8'd1,   8'h2B, "round_55_1");
        step_const(8'hFF, 8'd1,   8'h00, "round_ff_1");
        step_const(8'h55, 8'd3,   8'h0B, "round_55_3");
        step_const(8'h80, 8'd2,   8'hE0, "round_80_2");
        step_const(8'h7F, 8'd7,   8'h01, "round_7f_7");
        step_const(8'h80, 8'd200, 8'h00, "round_80_200");
        step_const(8'h01, 8'd255, 8'h00, "round_01_255");
`else
        step_const(8'h55, 8'd1,   8'h2A, "pos_shift_1");
        step_const(8'hFF, 8'd1,   8'hFF, "sign_ff_1");
        step_const(8'h55, 8'd3,   8'h0A, "pos_shift_3");
        step_const(8'h80, 8'd2,   8'hE0, "sign_80_2");
        step_const(8'h7F, 8'd7,   8'h00, "sat_7f_7");
        step_const(8'h80, 8'd200, 8'hFF, "sat_80_200");
        step_const(8'h01, 8'd255, 8'h00, "sat_01_255");
        step_const(8'h80, 8'd7,   8'hFF, "sat_80_7");
        step_const(8'h80, 8'd8,   8'hFF, "sat_80_8");
`endif

        // Mid-stream reset: clears immediately, holds through an edge, recovers on the next edge.
        step_const(8'h40, 8'd0, 8'h40, "pre_midreset");
        @(negedge clk);
        data_in = 8'h33;
        #1;
        rst = 1'b1;
        #1;
        check("midreset_async", 8'h00);
        @(posedge clk);
        #1;
        check("midreset_hold", 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_release", 8'h33);

        for (int i = 0; i < 300; i++) begin
            d = WIDTH'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       s = SHW'($urandom_range(0, 255));
                1:       s = SHW'($urandom_range(WIDTH - 2, WIDTH + 1));
                default: s = SHW'($urandom_range(0, WIDTH - 1));
            endcase
            if (i % 37 == 0) d = (i % 2 == 0) ? 8'h80 : 8'h7F;
            step(d, s, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
